// File: rtl/display_scanner.sv
// display_scanner: four-digit seven-segment refresh scanner with frame-synchronous double-buffered data and PWM brightness
module display_scanner #(
  parameter int DIV_WIDTH    = 17,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] val_in,
  input  logic [3:0] lower_in,
  input  logic [3:0] upper_in,
  input  logic [3:0] duty,
  output logic [3:0] anode,
  output logic [7:0] Val,
  output logic [3:0] lowerY,
  output logic [3:0] upperY,
  output logic       pending,
  output logic       frame_tick
);
  localparam logic [DIV_WIDTH-1:0] BLANK = DIV_WIDTH'(BLANK_CYCLES);
  logic [DIV_WIDTH-1:0] cnt;
  logic [1:0] idx;
  logic en_q, slot_end, frame_end, commit, lit;
  logic [3:0] sh_val, sh_lo, sh_up, sh_duty, act_val, act_lo, act_up, act_duty;
  assign slot_end  = enable && &cnt;
  assign frame_end = slot_end && idx == 2'd3;
  assign commit    = frame_end && pending;
  // dead time at slot start, then lit while the slot's top nibble is within duty
  assign lit    = en_q && cnt >= BLANK && cnt[DIV_WIDTH-1 -: 4] <= act_duty;
  assign anode  = lit ? ~(4'b0001 << idx) : 4'hf;
  assign Val    = {4'b0, act_val};
  assign lowerY = act_lo;
  assign upperY = act_up;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      en_q       <= 1'b0;
      sh_val     <= '0;
      sh_lo      <= '0;
      sh_up      <= '0;
      sh_duty    <= 4'hf;
      act_val    <= '0;
      act_lo     <= '0;
      act_up     <= '0;
      act_duty   <= 4'hf;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      en_q       <= enable;
      frame_tick <= frame_end;
      if (enable) cnt <= cnt + 1'b1;
      if (slot_end) idx <= idx + 1'b1;
      if (load) {sh_val, sh_lo, sh_up, sh_duty} <= {val_in, lower_in, upper_in, duty};
      if (commit) {act_val, act_lo, act_up, act_duty} <= {sh_val, sh_lo, sh_up, sh_duty};
      pending <= load || (pending && !commit);
    end
  end
endmodule

// File: doc/display_scanner.md
# display_scanner

Upstream driver for `seven_seg_decoder`: owns the digit-refresh timing for the four-digit seven-segment display. It rotates the active-low `anode` one-hot and presents the `Val`, `lowerY` and `upperY` nibbles the decoder consumes. New values and brightness are double-buffered and committed only at frame boundaries, so no digit ever shows a mix of old and new data. A per-slot dead time and a 16-step brightness PWM suppress ghosting.

## Interface
- `DIV_WIDTH`, default 17: width of the slot counter; one digit slot = 2**DIV_WIDTH clocks (1.31 ms at 100 MHz). Minimum 6.
- `BLANK_CYCLES`, default 16: dead-time clocks at the start of each slot with all anodes off. Must be < 2**(DIV_WIDTH-4).
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  1 = scan; 0 = freeze counters and blank the display.
- `load`  in  1  one-cycle strobe; captures `val_in`/`lower_in`/`upper_in`/`duty` into the shadow registers.
- `val_in`  in  4  right-digit nibble.
- `lower_in`  in  4  left-center-digit nibble.
- `upper_in`  in  4  left-digit nibble.
- `duty`  in  4  brightness; 15 = full, 0 = 1/16.
- `anode`  out  4  active-low digit enable, to the decoder and the pins.
- `Val`  out  8  `{4'b0, active val}`.
- `lowerY`  out  4  active lower nibble.
- `upperY`  out  4  active upper nibble.
- `pending`  out  1  the shadow holds an uncommitted load.
- `frame_tick`  out  1  one-cycle pulse when a commit point occurs.

## Operation
- State: `cnt[DIV_WIDTH-1:0]`, `idx[1:0]`, `en_q`, shadow {val, lower, upper, duty}, active {val, lower, upper, duty}, `pending`, `frame_tick`.
- Every edge: `en_q <= enable`.
- When `enable` = 1, `cnt <= cnt+1`, wrapping naturally.
- Slot end: `cnt` = all-ones with `enable` = 1. On a slot end, `idx <= idx+1` (3 wraps to 0).
- Frame end: slot end with `idx` = 3.
- Digit order: `idx` 0 → `anode` 1110 (right), 1 → 1101 (right center), 2 → 1011 (left center), 3 → 0111 (left).
- Lit condition: `en_q` AND `cnt` >= `BLANK_CYCLES` AND `cnt[DIV_WIDTH-1:DIV_WIDTH-4]` <= active duty. Otherwise `anode` = 1111.
- `anode` is decoded from registers only; there is no input-to-output combinational path.
- Load: on `load`, the shadow captures all four inputs and `pending <= 1`. A load while pending overwrites the shadow.
- Commit: at frame end with `pending` = 1, active <= shadow. `frame_tick` pulses on every frame end, whether or not a commit occurs.
- `pending` clears at commit, unless `load` is also asserted in that same cycle. In that case:
  - the active registers take the old shadow;
  - the new data enters the shadow;
  - `pending` stays 1.
- The right-center digit is fed 0 by the decoder; this block still scans its slot.
- While disabled: `cnt`, `idx`, shadow and active registers hold; loads are still accepted; no commits occur.

## Timing
- Reset values: `cnt` = 0, `idx` = 0, `en_q` = 0, `anode` = 1111, `Val` = 0, `lowerY` = 0, `upperY` = 0, active and shadow duty = 15, `pending` = 0, `frame_tick` = 0.
- Reset mid-operation discards pending data and returns every register to its reset value on that edge.
- `frame_tick` is registered: it is high during the first cycle of the new frame (`cnt` = 0, `idx` = 0). Committed values are visible on `Val`/`lowerY`/`upperY` in that same cycle.
- Load-to-output latency is 1 to 4·2**DIV_WIDTH clocks, depending on frame position. `pending` rises the cycle after `load`.
- `enable` deasserted: `anode` goes to 1111 one cycle later, via `en_q`. On reassertion, scanning resumes at the frozen `cnt`/`idx`.
- Frame period is 4·2**DIV_WIDTH clocks.

## Test plan
All scenarios use `DIV_WIDTH` = 6 and `BLANK_CYCLES` = 2, giving 64-clock slots, 4-clock PWM phases and 256-clock frames.
- Reset, then `enable` = 1 and no loads → `anode` sequence: 1111 for `cnt` 0–1, 1110 for `cnt` 2–63; at `cnt` 0 of slot 1, 1111 for 2 clocks, then 1101; then 1011, 0111. `frame_tick` pulses every 256 clocks; `Val` = 0.
- `load` with val = 5, lower = A, upper = 3 at `idx` = 1 → `pending` = 1 next cycle, outputs unchanged. At the next frame start: `frame_tick` = 1, `Val` = 8'h05, `lowerY` = A, upperY = 3, `pending` = 0.
- Pending shadow holds 1/2/3. `load` of 7/8/9 is asserted in the frame-end cycle → outputs become 1/2/3 and `pending` stays 1. One frame later, outputs become 7/8/9 and `pending` = 0.
- `load` with `duty` = 3, committed → per slot, lit only for `cnt` 2–15; 1111 for `cnt` 16–63.
- `enable` = 0 at `idx` = 2, `cnt` = 20, held for 50 clocks → `anode` = 1111 from the next cycle, `cnt`/`idx` frozen, no `frame_tick`. On re-enable: `anode` = 1011, counting continues from 20.
- `rst_n` = 0 for one edge mid-frame with `pending` = 1 → after that edge: `pending` = 0, `Val` = 0, `anode` = 1111, `cnt` = 0, `idx` = 0.
